mem_bus_ctrl: RTL and testbench

- Memory-access sequencer directly downstream of the address registers.
- Consumes the 16-bit address they drive onto the address bus, plus the CPU data bus.
- Runs one read or write transaction per request against an external memory with a variable-latency ready handshake.
- Returns read data onto the shared data bus through a tristate output.
- Reports busy, done and timeout status to the control unit.

---
 rtl/mem_bus_ctrl_pkg.sv | 16 +
 rtl/mem_bus_ctrl_wait_counter.sv | 29 ++
 rtl/mem_bus_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_bus_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the memory-access sequencer: FSM state encoding,
// default bus width and the default ready-timeout.
package mem_bus_ctrl_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned TIMEOUT_DEF    = 16;
  localparam int unsigned WAIT_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_bus_ctrl_wait_counter.sv
// Wait-state counter: counts strobe cycles without mem_ready and flags the
// last permitted cycle before timeout.
module wait_counter
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WAIT_CNT_WIDTH-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == WAIT_CNT_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-access sequencer: runs one read or write per request against a
// variable-latency memory and returns read data on the shared tristate bus.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = 2 * DATA_WIDTH,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CS,
  input  logic                  RD,
  input  logic                  WR,
  input  logic                  OE,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_re,
  output logic                  mem_we,
  input  logic                  mem_ready
);

  state_t                state, state_nxt;
  logic                  is_read;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_reg;
  logic                  accept, illegal;
  logic                  cnt_clr, cnt_en, expired;

  wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    illegal   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        accept  = CS && (RD ^ WR);
        illegal = CS && RD && WR;
        if (accept) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        cnt_clr   = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        // mem_ready is checked first so a late ready beats the timeout
        if (mem_ready || expired) begin
          state_nxt = DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_read   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_reg    <= '0;
      err       <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (accept) begin
        mem_addr <= address;
        is_read  <= RD;
        err      <= 1'b0;
        rd_valid <= 1'b0;
        if (WR) begin
          mem_wdata <= data;
        end
      end else if (illegal) begin
        err <= 1'b1;
      end
      if (state == ACCESS) begin
        if (mem_ready) begin
          if (is_read) begin
            rd_reg   <= mem_rdata;
            rd_valid <= 1'b1;
          end
        end else if (expired) begin
          err <= 1'b1;
        end
      end
    end
  end

  // Status and strobes decode straight from state so reset drops them at once
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign mem_re = (state == ACCESS) && is_read;
  assign mem_we = (state == ACCESS) && !is_read;

  assign data = (CS && OE && rd_valid) ? rd_reg : 'z;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl; pull-ups on data make a released bus read 8'hFF.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset, CS, RD, WR, OE;
  logic [15:0] address;
  logic [7:0]  mem_rdata, drv;
  logic        drv_en;
  wire  [7:0]  data;
  logic        busy, done, err, mem_re, mem_we, mem_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;

  int wait_n = 0;
  int acc_cnt = 0;
  int re_tot = 0, we_tot = 0, done_tot = 0;
  int n_cmp = 0, n_err = 0;
  int r0, w0, d0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (data[i]);
  end

  assign data      = drv_en ? drv : 'z;
  assign mem_ready = (mem_re || mem_we) && (acc_cnt >= wait_n);

  // acc_cnt = number of strobe cycles already completed in this access
  always @(posedge clk) acc_cnt <= (mem_re || mem_we) ? acc_cnt + 1 : 0;

  always @(negedge clk) begin
    re_tot   <= re_tot + int'(mem_re);
    we_tot   <= we_tot + int'(mem_we);
    done_tot <= done_tot + int'(done);
  end

  mem_bus_ctrl #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (16),
    .TIMEOUT    (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .CS        (CS),
    .RD        (RD),
    .WR        (WR),
    .OE        (OE),
    .address   (address),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_ready (mem_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    r0 = re_tot;
    w0 = we_tot;
    d0 = done_tot;
  endtask

  task automatic do_txn(input bit rd, input logic [15:0] a, input logic [7:0] wd, input int wn);
    wait_n  = wn;
    address = a;
    CS      = 1'b1;
    RD      = rd;
    WR      = !rd;
    drv     = wd;
    drv_en  = !rd;
    tick();
    RD     = 1'b0;
    WR     = 1'b0;
    drv_en = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      tick();
    end
    check("txn_idle", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    CS        = 1'b0;
    RD        = 1'b0;
    WR        = 1'b0;
    OE        = 1'b0;
    address   = '0;
    mem_rdata = '0;
    drv       = '0;
    drv_en    = 1'b0;
    #12;
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_flags", {28'b0, done, err, mem_re, mem_we}, 32'd0);
    check("rst_addr",  {16'b0, mem_addr}, 32'd0);
    check("rst_wdata", {24'b0, mem_wdata}, 32'd0);
    CS = 1'b1;
    OE = 1'b1;
    #1;
    check("rst_data_z", {24'b0, data}, 32'hFF);
    OE = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // zero-wait read
    tick();
    mem_rdata = 8'hA5;
    wait_n    = 0;
    address   = 16'h1234;
    RD        = 1'b1;
    snap();
    tick();
    RD = 1'b0;
    check("rd_setup_busy", {31'b0, busy}, 32'd1);
    check("rd_setup_addr", {16'b0, mem_addr}, 32'h1234);
    check("rd_setup_re",   {31'b0, mem_re}, 32'd0);
    tick();
    check("rd_access_re",  {31'b0, mem_re}, 32'd1);
    check("rd_access_done", {31'b0, done}, 32'd0);
    tick();
    check("rd_done_re",    {31'b0, mem_re}, 32'd0);
    check("rd_done_pulse", {30'b0, done, busy}, 32'd3);
    tick();
    check("rd_idle",       {30'b0, done, busy}, 32'd0);
    check("rd_re_cycles",  re_tot - r0, 32'd1);
    check("rd_done_count", done_tot - d0, 32'd1);
    OE = 1'b1;
    #1;
    check("rd_oe_data", {24'b0, data}, 32'hA5);
    mem_rdata = 8'h5A;
    #1;
    check("rd_oe_latched", {24'b0, data}, 32'hA5);
    OE = 1'b0;
    #1;
    check("rd_noe_z", {24'b0, data}, 32'hFF);

    // write with four wait states
    snap();
    do_txn(1'b0, 16'h00FF, 8'h3C, 4);
    check("wr_we_cycles", we_tot - w0, 32'd5);
    check("wr_re_cycles", re_tot - r0, 32'd0);
    check("wr_done",      done_tot - d0, 32'd1);
    check("wr_wdata",     {24'b0, mem_wdata}, 32'h3C);
    check("wr_addr",      {16'b0, mem_addr}, 32'h00FF);
    check("wr_err",       {31'b0, err}, 32'd0);
    OE = 1'b1;
    #1;
    check("wr_oe_z", {24'b0, data}, 32'hFF);
    OE = 1'b0;

    // read that times out
    mem_rdata = 8'h99;
    snap();
    do_txn(1'b1, 16'h4000, 8'h00, 255);
    check("to_re_cycles", re_tot - r0, 32'd16);
    check("to_err",       {31'b0, err}, 32'd1);
    check("to_done",      done_tot - d0, 32'd1);
    OE = 1'b1;
    #1;
    check("to_oe_z", {24'b0, data}, 32'hFF);
    OE = 1'b0;

    // ready on the last permitted strobe cycle
    mem_rdata = 8'hC3;
    snap();
    do_txn(1'b1, 16'h4001, 8'h00, 15);
    check("late_re_cycles", re_tot - r0, 32'd16);
    check("late_err",       {31'b0, err}, 32'd0);
    OE = 1'b1;
    #1;
    check("late_oe_data", {24'b0, data}, 32'hC3);
    OE = 1'b0;

    // RD and WR together
    snap();
    RD = 1'b1;
    WR = 1'b1;
    tick();
    RD = 1'b0;
    WR = 1'b0;
    check("ill_err",  {31'b0, err}, 32'd1);
    check("ill_busy", {31'b0, busy}, 32'd0);
    tick();
    tick();
    check("ill_no_strobe", (re_tot - r0) + (we_tot - w0), 32'd0);

    // WR pulses while a read is busy are dropped
    mem_rdata = 8'h77;
    wait_n    = 3;
    address   = 16'h2222;
    snap();
    RD = 1'b1;
    tick();
    RD = 1'b0;
    WR = 1'b1;
    tick();
    WR = 1'b0;
    tick();
    WR = 1'b1;
    tick();
    WR = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!busy) break;
      tick();
    end
    tick();
    tick();
    tick();
    check("busy_wr_idle",  {31'b0, busy}, 32'd0);
    check("busy_wr_done",  done_tot - d0, 32'd1);
    check("busy_wr_no_we", we_tot - w0, 32'd0);
    check("busy_wr_re",    re_tot - r0, 32'd4);
    check("busy_wr_err",   {31'b0, err}, 32'd0);
    OE = 1'b1;
    #1;
    check("busy_wr_data", {24'b0, data}, 32'h77);
    OE = 1'b0;

    // asynchronous reset mid-access
    wait_n  = 255;
    address = 16'hBEEF;
    RD      = 1'b1;
    tick();
    RD = 1'b0;
    tick();
    tick();
    check("arst_pre_re", {31'b0, mem_re}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_re",   {31'b0, mem_re}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("arst_idle", {31'b0, busy}, 32'd0);
    check("arst_addr", {16'b0, mem_addr}, 32'd0);
    OE = 1'b1;
    #1;
    check("arst_data_z", {24'b0, data}, 32'hFF);
    OE = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
